bcd_seg_scanner: RTL and testbench

//  Downstream display stage for the BCD counters: captures a bus of packed BCD digits
//  (e.g. odd_bcd_counter count on digit 0) and time-multiplexes them onto a 7-segment bank.

---
 rtl/bcd_seg_scanner_if.sv | 14 +
 rtl/bcd_seg_scanner.sv | 106 ++++++++++
 tb/tb_bcd_seg_scanner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scanner_if.sv
// rtl/bcd_seg_scanner_if.sv - digit bus and display outputs of the BCD 7-segment scanner
interface bcd_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
    logic                    err;

    modport master (output bcd_in, load, input seg, an, frame_done, err);
    modport slave  (input bcd_in, load, output seg, an, frame_done, err);
endinterface

// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - double-buffered multiplexed BCD to 7-segment scanner
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    bcd_seg_scanner_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    pend_vld;
    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic                    cur_bad;
    logic [6:0]              cur_seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    hi_zero;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    assign tick = (div_cnt == DW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Walk digits from the most significant end so leading-zero runs are known per digit.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (display[4*k +: 4] == 4'd0);
            if (idx == IW'(k)) begin
                cur_digit = display[4*k +: 4];
                cur_blank = hi_zero && (k != 0);
            end
        end
`else
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) cur_digit = display[4*k +: 4];
        end
`endif
    end

    assign cur_bad = (cur_digit > 4'd9) && !cur_blank;
    assign cur_seg = cur_blank ? 7'h00 : seg_decode(cur_digit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt        <= '0;
            idx            <= '0;
            pending        <= '0;
            display        <= '0;
            pend_vld       <= 1'b0;
            bus.an         <= '1;
            bus.seg        <= SEG_OFF;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            bus.frame_done <= wrap;

            // A load landing on the boundary bypasses the pending buffer.
            if (bus.load && wrap) begin
                display  <= bus.bcd_in;
                pend_vld <= 1'b0;
            end else if (bus.load) begin
                pending  <= bus.bcd_in;
                pend_vld <= 1'b1;
            end else if (wrap && pend_vld) begin
                display  <= pending;
                pend_vld <= 1'b0;
            end

            bus.an  <= ~(NUM_DIGITS'(1) << idx);
            bus.seg <= (SEG_ACTIVE_LOW != 0) ? ~cur_seg : cur_seg;
            if (cur_bad) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - table-driven scoreboard bench for bcd_seg_scanner
module tb_bcd_seg_scanner;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam bit SEG_AL = 1'b0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    bcd_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(SEG_AL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       bad;
    } exp_t;

    // mode: 0 no load, 1 load at frame start, 2 decoy then value mid-frame, 3 load on wrap tick
    typedef struct packed {
        logic [15:0]     bcd;
        logic [15:0]     decoy;
        logic [1:0]      mode;
        logic [3:0][6:0] seg;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] pol(input logic [6:0] s);
        return SEG_AL ? ~s : s;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0][6:0] segs);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.an  = ~(4'b0001 << d);
            e.seg = segs[d];
            e.bad = (v[4*d +: 4] > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (v >> (4*d)) == 16'h0) begin
                e.seg = 7'h00;
                e.bad = 1'b0;
            end
`endif
            e.seg = pol(e.seg);
            sb.push_back(e);
        end
    endtask

    task automatic check_digit();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected >0");
        end else begin
            e = sb.pop_front();
            if (e.bad) err_exp = 1'b1;
            check("an", bus.an, e.an);
            check("seg", bus.seg, e.seg);
            check("err", bus.err, err_exp);
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic [15:0] val, input logic [15:0] decoy);
        if (mode == 2'd1) begin
            bus.bcd_in = val;
            bus.load   = 1'b1;
        end else if (mode == 2'd2) begin
            bus.bcd_in = decoy;
            bus.load   = 1'b1;
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            if (c % 4 == 0) check_digit();
            if (c == 0) check("frame_done_low", bus.frame_done, 1'b0);
            if (c == 15) check("frame_done_pulse", bus.frame_done, 1'b1);
            if ((mode == 2'd2 && c == 4) || (mode == 2'd3 && c == 14)) begin
                bus.bcd_in = val;
                bus.load   = 1'b1;
            end
        end
    endtask

    task automatic sync_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_sync", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{bcd: 16'h1359, decoy: 16'h0000, mode: 2'd1, seg: {7'h06, 7'h4F, 7'h6D, 7'h6F}};
        vecs[1] = '{bcd: 16'h0007, decoy: 16'h0005, mode: 2'd2, seg: {7'h3F, 7'h3F, 7'h3F, 7'h07}};
        vecs[2] = '{bcd: 16'h2468, decoy: 16'h0000, mode: 2'd3, seg: {7'h5B, 7'h66, 7'h7D, 7'h7F}};
        vecs[3] = '{bcd: 16'h00A7, decoy: 16'h0000, mode: 2'd1, seg: {7'h3F, 7'h3F, 7'h40, 7'h07}};
        vecs[4] = '{bcd: 16'h0009, decoy: 16'h0000, mode: 2'd1, seg: {7'h3F, 7'h3F, 7'h3F, 7'h6F}};
        vecs[5] = '{bcd: 16'h8F00, decoy: 16'h0000, mode: 2'd1, seg: {7'h7F, 7'h40, 7'h3F, 7'h3F}};

        bus.bcd_in = '0;
        bus.load   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, pol(7'h00));
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_err", bus.err, 1'b0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_an", bus.an, 4'hE);
        check("first_seg", bus.seg, pol(7'h3F));
        repeat (3) @(posedge clk);
        #1;
        check("digit0_held", bus.an, 4'hE);
        @(posedge clk);
        #1;
        check("digit1_after_div", bus.an, 4'hD);
        sync_frame();

        push_frame(16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
        for (int i = 0; i < 6; i++) begin
            push_frame(vecs[i].bcd, vecs[i].seg);
            run_frame(vecs[i].mode, vecs[i].bcd, vecs[i].decoy);
        end
        run_frame(2'd0, 16'h0000, 16'h0000);
        check("scoreboard_drained", sb.size(), 0);

        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_idx2", bus.an, 4'hB);
        check("pre_reset_err", bus.err, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_an", bus.an, 4'hF);
        check("async_rst_seg", bus.seg, pol(7'h00));
        check("async_rst_err", bus.err, 1'b0);
        err_exp = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("held_rst_an", bus.an, 4'hF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("restart_an", bus.an, 4'hE);
        repeat (4) @(posedge clk);
        #1;
        check("restart_digit1", bus.an, 4'hD);
        sync_frame();
        push_frame(16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
        run_frame(2'd0, 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
